// File: rtl/sr_bank_pkg.sv
// sr_bank_pkg: mode encoding shared by the shift-register bank and its control block
package sr_bank_pkg;
  typedef logic [1:0] sr_mode_t;
  localparam sr_mode_t MODE_HOLD   = 2'd0;
  localparam sr_mode_t MODE_SHIFT  = 2'd1;
  localparam sr_mode_t MODE_RECIRC = 2'd2;
  localparam sr_mode_t MODE_CLEAR  = 2'd3;
endpackage

// File: rtl/sr_bank_ctl.sv
// sr_bank_ctl: rotation position, frame-wrap pulse and saturating fill/full tracking
module sr_bank_ctl
  import sr_bank_pkg::*;
#(
  parameter int LENGTH = 400
) (
  input  logic                         clk,
  input  logic                         rst,
  input  sr_mode_t                     mode,
  output logic [$clog2(LENGTH)-1:0]    pos,
  output logic                         frame,
  output logic [$clog2(LENGTH+1)-1:0]  fill,
  output logic                         full
);
  localparam int PW = $clog2(LENGTH);
  localparam int FW = $clog2(LENGTH+1);
  localparam logic [PW-1:0] POS_LAST = PW'(LENGTH-1);
  localparam logic [FW-1:0] FILL_MAX = FW'(LENGTH);
  logic [PW-1:0] pos_q, pos_d;
  logic [FW-1:0] fill_q, fill_d;
  logic          frame_q, frame_d, full_q, full_d, adv, wrap;
  always_comb begin
    adv     = (mode == MODE_SHIFT) || (mode == MODE_RECIRC);
    wrap    = adv && (pos_q == POS_LAST);
    pos_d   = (mode == MODE_CLEAR) ? '0 : wrap ? '0 : adv ? pos_q + 1'b1 : pos_q;
    frame_d = wrap;
    fill_d  = (mode == MODE_CLEAR) ? '0 :
              ((mode == MODE_SHIFT) && (fill_q != FILL_MAX)) ? fill_q + 1'b1 : fill_q;
    full_d  = (fill_d == FILL_MAX);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q   <= '0;
      frame_q <= 1'b0;
      fill_q  <= '0;
      full_q  <= 1'b0;
    end else begin
      pos_q   <= pos_d;
      frame_q <= frame_d;
      fill_q  <= fill_d;
      full_q  <= full_d;
    end
  end
  assign pos   = pos_q;
  assign frame = frame_q;
  assign fill  = fill_q;
  assign full  = full_q;
endmodule

// File: rtl/sr_bank.sv
// sr_bank: WIDTH-channel, LENGTH-stage shift/recirculate storage with fill and frame tracking
// Optional tap output on stage TAP when SR_BANK_TAP_EN is defined.
module sr_bank
  import sr_bank_pkg::*;
#(
  parameter int WIDTH  = 6,
  parameter int LENGTH = 400,
  parameter int TAP    = LENGTH/2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  sr_mode_t                     mode,
  input  logic [WIDTH-1:0]             data_in,
  output logic [WIDTH-1:0]             data_out,
  output logic [$clog2(LENGTH)-1:0]    pos,
  output logic                         frame,
  output logic [$clog2(LENGTH+1)-1:0]  fill,
  output logic                         full
`ifdef SR_BANK_TAP_EN
  ,
  output logic [WIDTH-1:0]             tap_out
`endif
);
  if (WIDTH < 1 || LENGTH < 2 || TAP < 0 || TAP >= LENGTH) begin : g_bad_params
    $error("sr_bank: illegal parameters WIDTH=%0d LENGTH=%0d TAP=%0d", WIDTH, LENGTH, TAP);
  end
  logic [WIDTH-1:0] stage_q [LENGTH];
  logic [WIDTH-1:0] stage_d [LENGTH];
  always_comb begin
    stage_d = stage_q;
    if (mode == MODE_CLEAR) begin
      for (int k = 0; k < LENGTH; k++) stage_d[k] = '0;
    end else if (mode != MODE_HOLD) begin
      stage_d[0] = (mode == MODE_SHIFT) ? data_in : stage_q[LENGTH-1];
      for (int k = 1; k < LENGTH; k++) stage_d[k] = stage_q[k-1];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) stage_q <= '{default: '0};
    else stage_q <= stage_d;
  end
  assign data_out = stage_q[LENGTH-1];
`ifdef SR_BANK_TAP_EN
  assign tap_out = stage_q[TAP];
`endif
  sr_bank_ctl #(.LENGTH(LENGTH)) u_ctl (
    .clk   (clk),
    .rst   (rst),
    .mode  (mode),
    .pos   (pos),
    .frame (frame),
    .fill  (fill),
    .full  (full)
  );
endmodule

// File: tb/tb_sr_bank.sv
// tb_sr_bank: directed plus random checks of sr_bank against a queue-based reference model
module tb_sr_bank;
  import sr_bank_pkg::*;
  localparam int W = 6;
  localparam int L = 4;
  localparam int T = 1;
  logic clk = 1'b0;
  logic rst = 1'b0;
  sr_mode_t mode = MODE_HOLD;
  logic [W-1:0] data_in = '0;
  logic [W-1:0] data_out;
  logic [$clog2(L)-1:0] pos;
  logic frame, full;
  logic [$clog2(L+1)-1:0] fill;
`ifdef SR_BANK_TAP_EN
  logic [W-1:0] tap_out;
`endif
  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] m_q[$];
  int m_pos, m_fill;
  bit m_frame;

  sr_bank #(.WIDTH(W), .LENGTH(L), .TAP(T)) dut (
    .clk      (clk),
    .rst      (rst),
    .mode     (mode),
    .data_in  (data_in),
    .data_out (data_out),
    .pos      (pos),
    .frame    (frame),
    .fill     (fill),
    .full     (full)
`ifdef SR_BANK_TAP_EN
    ,
    .tap_out  (tap_out)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_q = {};
    for (int i = 0; i < L; i++) m_q.push_back('0);
    m_pos = 0;
    m_fill = 0;
    m_frame = 0;
  endtask

  task automatic step(input bit r, input sr_mode_t md, input logic [W-1:0] d);
    logic [W-1:0] last;
    rst = r;
    mode = md;
    data_in = d;
    @(posedge clk);
    m_frame = 0;
    if (r || md == MODE_CLEAR) model_clear();
    else if (md != MODE_HOLD) begin
      last = m_q.pop_back();
      m_q.push_front(md == MODE_SHIFT ? d : last);
      m_pos = (m_pos + 1) % L;
      m_frame = (m_pos == 0);
      if (md == MODE_SHIFT && m_fill < L) m_fill++;
    end
    #1;
    check("data_out", 32'(data_out), 32'(m_q[L-1]));
    check("pos", 32'(pos), 32'(m_pos));
    check("frame", 32'(frame), 32'(m_frame));
    check("fill", 32'(fill), 32'(m_fill));
    check("full", 32'(full), 32'(m_fill == L));
`ifdef SR_BANK_TAP_EN
    check("tap_out", 32'(tap_out), 32'(m_q[T]));
`endif
  endtask

  initial begin
    logic [W-1:0] snap[$];
    model_clear();
    #2;
    step(1, sr_mode_t'($urandom_range(3)), W'($urandom));
    for (int i = 1; i <= 5; i++) step(0, MODE_SHIFT, W'(i));
    check("latency_out", 32'(data_out), 32'h02);
    snap = m_q;
    for (int i = 0; i < L; i++) step(0, MODE_RECIRC, W'($urandom));
    check("recirc_return", 32'(data_out), 32'(snap[L-1]));
    check("recirc_fill", 32'(fill), 32'(L));
    step(0, MODE_CLEAR, W'($urandom));
    step(1, MODE_HOLD, '0);
    for (int i = 0; i < L; i++) step(0, MODE_SHIFT, W'($urandom));
    check("wrap_frame", 32'(frame), 32'd1);
    step(0, MODE_HOLD, '0);
    step(1, MODE_HOLD, '0);
    step(0, MODE_SHIFT, 6'h11);
    step(0, MODE_SHIFT, 6'h22);
    for (int i = 0; i < 3; i++) step(0, MODE_HOLD, W'($urandom));
    check("hold_pos", 32'(pos), 32'd2);
    check("hold_fill", 32'(fill), 32'd2);
    step(0, MODE_SHIFT, 6'h33);
    step(0, MODE_SHIFT, 6'h3F);
    check("hold_latency", 32'(data_out), 32'h11);
    step(1, MODE_SHIFT, 6'h3F);
    step(0, MODE_SHIFT, 6'h2A);
    step(0, MODE_SHIFT, 6'h15);
    for (int i = 0; i < 400; i++)
      step(($urandom_range(31) == 0), sr_mode_t'($urandom_range(3) == 3 && $urandom_range(7) != 0 ?
           MODE_SHIFT : $urandom_range(3)), W'($urandom));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
